// File: rtl/dmem_banked.sv
// Word-organised data memory with byte-enabled writes, a REQ/READY handshake,
// a READ_LAT-deep read pipeline and a post-reset hardware clear of every word.
module dmem_banked #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 48,
  parameter int ADDR_WIDTH = 32,
  parameter int READ_LAT   = 1
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    REQ,
  input  logic                    WE,
  input  logic [DATA_WIDTH/8-1:0] BE,
  input  logic [ADDR_WIDTH-1:0]   ADRS,
  input  logic [DATA_WIDTH-1:0]   WD,
  output logic                    READY,
  output logic                    RVALID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic                    ERR
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SHIFT = $clog2(BYTES);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  clr_idx, clr_idx_nxt;
  logic              clr_we;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] word_addr;
  logic [IDX_W-1:0]      idx;
  logic                  misaligned, out_of_range, req_err;
  logic                  acc, rd_acc, wr_acc, wr_ok;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [READ_LAT-1:0]   vld_p, rerr_p;
  logic [DATA_WIDTH-1:0] rdata_p [READ_LAT];
  logic                  werr_p0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  // The clear walks every index once; the edge that zeroes the last word also enters RUN.
  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    clr_we      = 1'b0;
    READY       = 1'b0;
    case (state)
      CLEAR: begin
        clr_we      = 1'b1;
        clr_idx_nxt = clr_idx + IDX_W'(1);
        if (clr_idx == IDX_W'(DEPTH - 1)) begin
          state_nxt   = RUN;
          clr_idx_nxt = '0;
        end
      end
      RUN:     READY = 1'b1;
      default: state_nxt = CLEAR;
    endcase
  end

  assign word_addr    = ADRS >> SHIFT;
  assign idx          = word_addr[IDX_W-1:0];
  assign misaligned   = (ADRS & ADDR_WIDTH'(BYTES - 1)) != '0;
  assign out_of_range = word_addr >= ADDR_WIDTH'(DEPTH);
  assign req_err      = misaligned | out_of_range;

  assign acc    = REQ & READY;
  assign rd_acc = acc & ~WE;
  assign wr_acc = acc & WE;
  assign wr_ok  = wr_acc & ~req_err;

  // Read-first: the word is sampled before this edge's write can land.
  assign rd_word = req_err ? '0 : mem[idx];

  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem[clr_idx] <= '0;
    end else if (wr_ok) begin
      for (int b = 0; b < BYTES; b++) begin
        if (BE[b]) mem[idx][8*b +: 8] <= WD[8*b +: 8];
      end
    end
  end

  // Stage p0 captures at acceptance; later stages only delay the result.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_p   <= '0;
      rerr_p  <= '0;
      werr_p0 <= 1'b0;
    end else begin
      vld_p[0]  <= rd_acc;
      rerr_p[0] <= rd_acc & req_err;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_p[i]  <= vld_p[i-1];
        rerr_p[i] <= rerr_p[i-1];
      end
      werr_p0 <= wr_acc & req_err;
    end
  end

  always_ff @(posedge CLK) begin
    rdata_p[0] <= rd_word;
    for (int i = 1; i < READ_LAT; i++) begin
      rdata_p[i] <= rdata_p[i-1];
    end
  end

  // Data stages are unreset, so the output is forced to zero whenever no read completes.
  assign RVALID = vld_p[READ_LAT-1];
  assign RDATA  = RVALID ? rdata_p[READ_LAT-1] : '0;
  assign ERR    = (RVALID & rerr_p[READ_LAT-1]) | werr_p0;

endmodule

// File: tb/tb_dmem_banked.sv
// Directed bench for dmem_banked: two instances (READ_LAT 2 and 3) share one stimulus.
module tb_dmem_banked;

  logic        CLK;
  logic        RST_N;
  logic        REQ;
  logic        WE;
  logic [3:0]  BE;
  logic [31:0] ADRS;
  logic [31:0] WD;

  logic        ready2, rvalid2, err2;
  logic [31:0] rdata2;
  logic        ready3, rvalid3, err3;
  logic [31:0] rdata3;

  int checks;
  int errors;

  dmem_banked #(.DATA_WIDTH(32), .DEPTH(48), .ADDR_WIDTH(32), .READ_LAT(2)) dut2 (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .WE(WE), .BE(BE), .ADRS(ADRS), .WD(WD),
    .READY(ready2), .RVALID(rvalid2), .RDATA(rdata2), .ERR(err2)
  );

  dmem_banked #(.DATA_WIDTH(32), .DEPTH(48), .ADDR_WIDTH(32), .READ_LAT(3)) dut3 (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .WE(WE), .BE(BE), .ADRS(ADRS), .WD(WD),
    .READY(ready3), .RVALID(rvalid3), .RDATA(rdata3), .ERR(err3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    REQ = 1'b0;
    WE  = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // One request accepted on the next edge; returns just after that edge.
  task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] adrs,
                       input logic [31:0] wd);
    REQ = 1'b1; WE = we; BE = be; ADRS = adrs; WD = wd;
    tick();
    REQ = 1'b0; WE = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; REQ = 1'b0; WE = 1'b0; BE = '0; ADRS = '0; WD = '0;
    idle(3);
    checks++;
    if ({ready2, rvalid2, err2, rdata2} !== 35'd0 || {ready3, rvalid3, err3, rdata3} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs got2=%h got3=%h expected=0", {ready2, rvalid2, err2, rdata2},
               {ready3, rvalid3, err3, rdata3});
    end
  endtask

  task automatic test_clear();
    int n;
    RST_N = 1'b1;
    checks++;
    if (ready2 !== 1'b0) begin
      errors++;
      $display("FAIL clear_ready_at_release got=%b expected=0", ready2);
    end
    n = 0;
    while (ready2 !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 48 || ready3 !== 1'b1) begin
      errors++;
      $display("FAIL clear_length got=%0d cycles (ready3=%b) expected=48 cycles", n, ready3);
    end
    for (int k = 0; k <= 48; k++) begin
      REQ = (k < 48); WE = 1'b0; ADRS = 32'(k * 4);
      tick();
      if (k >= 1) begin
        checks++;
        if ({rvalid2, err2, rdata2} !== {1'b1, 1'b0, 32'd0}) begin
          errors++;
          $display("FAIL clear_read_word%0d got=%h expected=%h", k - 1, {rvalid2, err2, rdata2},
                   {1'b1, 1'b0, 32'd0});
        end
      end
    end
    idle(4);
  endtask

  task automatic test_byte_enable();
    issue(1'b1, 4'b1111, 32'h10, 32'h11223344);
    issue(1'b1, 4'b0101, 32'h10, 32'hAABBCCDD);
    issue(1'b0, 4'b0000, 32'h10, 32'h0);
    checks++;
    if (rvalid2 !== 1'b0 || rvalid3 !== 1'b0) begin
      errors++;
      $display("FAIL be_early_rvalid got=%b%b expected=00", rvalid2, rvalid3);
    end
    tick();
    checks++;
    if ({rvalid2, err2, rdata2} !== {1'b1, 1'b0, 32'h11BB33DD} || rvalid3 !== 1'b0) begin
      errors++;
      $display("FAIL be_read_lat2 got=%h rvalid3=%b expected=%h rvalid3=0", {rvalid2, err2, rdata2},
               rvalid3, {1'b1, 1'b0, 32'h11BB33DD});
    end
    tick();
    checks++;
    if ({rvalid3, err3, rdata3} !== {1'b1, 1'b0, 32'h11BB33DD} || {rvalid2, rdata2} !== 33'd0) begin
      errors++;
      $display("FAIL be_read_lat3 got=%h lat2=%h expected=%h lat2=0", {rvalid3, err3, rdata3},
               {rvalid2, rdata2}, {1'b1, 1'b0, 32'h11BB33DD});
    end
    idle(4);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [3];
    exp_d[0] = 32'd1; exp_d[1] = 32'd2; exp_d[2] = 32'd3;
    issue(1'b1, 4'b1111, 32'h0, 32'd1);
    issue(1'b1, 4'b1111, 32'h4, 32'd2);
    issue(1'b1, 4'b1111, 32'h8, 32'd3);
    for (int k = 0; k < 5; k++) begin
      REQ = (k < 3); WE = 1'b0; ADRS = 32'(k * 4);
      tick();
      if (k >= 1 && k <= 3) begin
        checks++;
        if ({rvalid2, err2, rdata2} !== {1'b1, 1'b0, exp_d[k-1]}) begin
          errors++;
          $display("FAIL b2b_read%0d got=%h expected=%h", k - 1, {rvalid2, err2, rdata2},
                   {1'b1, 1'b0, exp_d[k-1]});
        end
      end
    end
    checks++;
    if ({rvalid2, rdata2} !== 33'd0) begin
      errors++;
      $display("FAIL b2b_pulse_end got=%h expected=0", {rvalid2, rdata2});
    end
    idle(4);
  endtask

  task automatic test_errors();
    issue(1'b0, 4'b0000, 32'h6, 32'h0);
    tick();
    checks++;
    if ({rvalid2, err2, rdata2} !== {1'b1, 1'b1, 32'd0}) begin
      errors++;
      $display("FAIL misaligned_read got=%h expected=%h", {rvalid2, err2, rdata2}, {1'b1, 1'b1, 32'd0});
    end
    idle(3);
    issue(1'b1, 4'b1111, 32'hC0, 32'hDEADBEEF);
    checks++;
    if ({err2, rvalid2, err3, rvalid3} !== 4'b1010) begin
      errors++;
      $display("FAIL oor_write_err got=%b expected=1010", {err2, rvalid2, err3, rvalid3});
    end
    tick();
    checks++;
    if ({err2, err3} !== 2'b00) begin
      errors++;
      $display("FAIL oor_write_err_len got=%b expected=00", {err2, err3});
    end
    issue(1'b0, 4'b0000, 32'h0, 32'h0);
    tick();
    checks++;
    if ({rvalid2, err2, rdata2} !== {1'b1, 1'b0, 32'd1}) begin
      errors++;
      $display("FAIL oor_word0_intact got=%h expected=%h", {rvalid2, err2, rdata2}, {1'b1, 1'b0, 32'd1});
    end
    idle(3);
    issue(1'b0, 4'b0000, 32'hC0, 32'h0);
    tick();
    checks++;
    if ({rvalid2, err2, rdata2} !== {1'b1, 1'b1, 32'd0}) begin
      errors++;
      $display("FAIL oor_read got=%h expected=%h", {rvalid2, err2, rdata2}, {1'b1, 1'b1, 32'd0});
    end
    idle(3);
    issue(1'b1, 4'b0000, 32'h4, 32'hFFFFFFFF);
    checks++;
    if (err2 !== 1'b0) begin
      errors++;
      $display("FAIL be_zero_err got=%b expected=0", err2);
    end
    issue(1'b0, 4'b0000, 32'h4, 32'h0);
    tick();
    checks++;
    if ({rvalid2, err2, rdata2} !== {1'b1, 1'b0, 32'd2}) begin
      errors++;
      $display("FAIL be_zero_noop got=%h expected=%h", {rvalid2, err2, rdata2}, {1'b1, 1'b0, 32'd2});
    end
    idle(4);
  endtask

  task automatic test_hazard();
    issue(1'b1, 4'b1111, 32'h20, 32'd5);
    REQ = 1'b1; WE = 1'b0; ADRS = 32'h20;
    tick();
    WE = 1'b1; BE = 4'b1111; WD = 32'd9;
    tick();
    REQ = 1'b0; WE = 1'b0;
    checks++;
    if ({rvalid2, err2, rdata2} !== {1'b1, 1'b0, 32'd5}) begin
      errors++;
      $display("FAIL hazard_old_data got=%h expected=%h", {rvalid2, err2, rdata2}, {1'b1, 1'b0, 32'd5});
    end
    idle(3);
    issue(1'b0, 4'b0000, 32'h20, 32'h0);
    tick();
    checks++;
    if ({rvalid2, err2, rdata2} !== {1'b1, 1'b0, 32'd9}) begin
      errors++;
      $display("FAIL hazard_new_data got=%h expected=%h", {rvalid2, err2, rdata2}, {1'b1, 1'b0, 32'd9});
    end
    idle(4);
  endtask

  task automatic test_reset_mid();
    int n;
    int seen;
    REQ = 1'b1; WE = 1'b0; ADRS = 32'h0;
    tick();
    ADRS = 32'h4;
    tick();
    REQ = 1'b0;
    RST_N = 1'b0;
    #1;
    checks++;
    if ({ready3, rvalid3, ready2, rvalid2} !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_immediate got=%b expected=0000", {ready3, rvalid3, ready2, rvalid2});
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rvalid3 || rvalid2) seen++;
    end
    RST_N = 1'b1;
    n = 0;
    while (ready3 !== 1'b1 && n < 200) begin
      if (rvalid3 || rvalid2) seen++;
      tick();
      n++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midreset_no_rvalid got=%0d pulses expected=0", seen);
    end
    checks++;
    if (n !== 48) begin
      errors++;
      $display("FAIL midreset_clear_length got=%0d cycles expected=48", n);
    end
    for (int k = 0; k <= 50; k++) begin
      REQ = (k < 48); WE = 1'b0; ADRS = 32'(k * 4);
      tick();
      if (k >= 2 && k <= 49) begin
        checks++;
        if ({rvalid3, err3, rdata3} !== {1'b1, 1'b0, 32'd0}) begin
          errors++;
          $display("FAIL midreset_read_word%0d got=%h expected=%h", k - 2, {rvalid3, err3, rdata3},
                   {1'b1, 1'b0, 32'd0});
        end
      end
    end
    idle(4);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_clear();
    test_byte_enable();
    test_back_to_back();
    test_errors();
    test_hazard();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
